// File: rtl/counter_checker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker_pkg
// Description : Shared types for the counter stream checker. Holds the
//               checker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_checker_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage : counter_checker_pkg
`default_nettype wire

// File: rtl/counter_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker_if
// Description : Bundle between a counter stream source and the checker.
//               en/in/clr_err flow from master to slave.
//               locked/error/err_count flow back from slave to master.
//   en        - in carries a valid sample this cycle
//   in        - sample under test
//   clr_err   - synchronous clear of err_count
//   locked    - checker is locked to the stream
//   error     - one-cycle pulse per bad sample while locked
//   err_count - saturating count of bad samples
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_checker_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 16
);
    logic                  en;
    logic [DATA_WIDTH-1:0] in;
    logic                  clr_err;
    logic                  locked;
    logic                  error;
    logic [ERR_WIDTH-1:0]  err_count;

    modport master (
        output en, in, clr_err,
        input  locked, error, err_count
    );

    modport slave (
        input  en, in, clr_err,
        output locked, error, err_count
    );
endinterface : counter_checker_if
`default_nettype wire

// File: rtl/counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : counter_checker
// Description : Receive-side checker for a COUNT_FROM..COUNT_TO/STEP counter
//               stream. Locks after LOCK_COUNT consecutive correct samples,
//               then flags and counts each bad sample, and drops lock after
//               UNLOCK_COUNT consecutive bad samples. All outputs registered.
//   clk - clock, rising edge
//   rst - synchronous reset, active low
//   bus - slave side of counter_checker_if (en, in, clr_err -> locked,
//         error, err_count)
// Revision    : 1.0 - initial release
// ============================================================================
module counter_checker
    import counter_checker_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int COUNT_FROM   = 0,
    parameter int COUNT_TO     = 255,
    parameter int STEP         = 1,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 3,
    parameter int ERR_WIDTH    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst,
    counter_checker_if.slave  bus
);

    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int MISS_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [DATA_WIDTH-1:0] c_from      = DATA_WIDTH'(COUNT_FROM);
    localparam logic [DATA_WIDTH-1:0] c_to        = DATA_WIDTH'(COUNT_TO);
    localparam logic [DATA_WIDTH-1:0] c_step      = DATA_WIDTH'(STEP);
    localparam logic [MATCH_W-1:0]    c_lock_last = MATCH_W'(LOCK_COUNT - 1);
    localparam logic [MISS_W-1:0]     c_unl_last  = MISS_W'(UNLOCK_COUNT - 1);

    // Successor in the counter sequence; the add wraps modulo 2^DATA_WIDTH.
    function automatic logic [DATA_WIDTH-1:0] next_count(input logic [DATA_WIDTH-1:0] x);
        return (x == c_to) ? c_from : x + c_step;
    endfunction

    state_t                r_state,    w_state_nxt;
    logic [DATA_WIDTH-1:0] r_expected, w_expected_nxt;
    logic [MATCH_W-1:0]    r_match,    w_match_nxt;
    logic [MISS_W-1:0]     r_miss,     w_miss_nxt;
    logic                  r_locked,   w_locked_nxt;
    logic                  r_error,    w_error_nxt;
    logic [ERR_WIDTH-1:0]  r_err_count;
    logic                  w_err_inc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= SEARCH;
            r_expected  <= '0;
            r_match     <= '0;
            r_miss      <= '0;
            r_locked    <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_expected <= w_expected_nxt;
            r_match    <= w_match_nxt;
            r_miss     <= w_miss_nxt;
            r_locked   <= w_locked_nxt;
            r_error    <= w_error_nxt;
            // Clear beats a same-cycle increment; the count holds at all-ones.
            if (bus.clr_err)
                r_err_count <= '0;
            else if (w_err_inc && (r_err_count != '1))
                r_err_count <= r_err_count + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_match_nxt    = r_match;
        w_miss_nxt     = r_miss;
        w_locked_nxt   = r_locked;
        w_error_nxt    = 1'b0;
        w_err_inc      = 1'b0;

        if (bus.en) begin
            case (r_state)
                SEARCH: begin
                    w_expected_nxt = next_count(bus.in);
                    w_match_nxt    = MATCH_W'(1);
                    w_state_nxt    = ACQUIRE;
                end

                ACQUIRE: begin
                    // Follow the stream either way; a mismatch just restarts the run.
                    w_expected_nxt = next_count(bus.in);
                    if (bus.in == r_expected) begin
                        w_match_nxt = r_match + 1'b1;
                        if (r_match == c_lock_last) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                            w_miss_nxt   = '0;
                        end
                    end else begin
                        w_match_nxt = MATCH_W'(1);
                    end
                end

                LOCKED: begin
                    // Flywheel on our own expectation so a bad sample cannot
                    // drag the reference along with it.
                    w_expected_nxt = next_count(r_expected);
                    if (bus.in == r_expected) begin
                        w_miss_nxt = '0;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_err_inc   = 1'b1;
                        if (r_miss == c_unl_last) begin
                            w_locked_nxt   = 1'b0;
                            w_state_nxt    = ACQUIRE;
                            w_expected_nxt = next_count(bus.in);
                            w_match_nxt    = MATCH_W'(1);
                            w_miss_nxt     = '0;
                        end else begin
                            w_miss_nxt = r_miss + 1'b1;
                        end
                    end
                end

                default: begin
                    w_state_nxt  = SEARCH;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    assign bus.locked    = r_locked;
    assign bus.error     = r_error;
    assign bus.err_count = r_err_count;

endmodule : counter_checker
`default_nettype wire

// File: tb/tb_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_checker
// Description : Directed self-checking bench for counter_checker. dut0 uses
//               the default 0..255 step 1 sequence, dut1 uses 10..20 step 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) bus0 ();
    counter_checker_if #(.DATA_WIDTH(8), .ERR_WIDTH(16)) bus1 ();

    counter_checker #(
        .DATA_WIDTH(8), .COUNT_FROM(0), .COUNT_TO(255), .STEP(1),
        .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_WIDTH(16)
    ) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    counter_checker #(
        .DATA_WIDTH(8), .COUNT_FROM(10), .COUNT_TO(20), .STEP(2),
        .LOCK_COUNT(4), .UNLOCK_COUNT(3), .ERR_WIDTH(16)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    logic seen0;
    logic seen1;
    logic [7:0] cur;
    logic [7:0] v1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic e, input logic [7:0] v);
        bus0.en = e;
        bus0.in = v;
        tick();
        seen0 = seen0 | bus0.error;
    endtask

    task automatic send1(input logic e, input logic [7:0] v);
        bus1.en = e;
        bus1.in = v;
        tick();
        seen1 = seen1 | bus1.error;
    endtask

    initial begin
        rst = 1'b0;
        bus0.en = 1'b0; bus0.in = '0; bus0.clr_err = 1'b0;
        bus1.en = 1'b0; bus1.in = '0; bus1.clr_err = 1'b0;
        seen0 = 1'b0; seen1 = 1'b0;
        tick();
        tick();
        check("rst_locked", {31'd0, bus0.locked}, 32'd0);
        check("rst_error",  {31'd0, bus0.error},  32'd0);
        check("rst_errcnt", {16'd0, bus0.err_count}, 32'd0);
        rst = 1'b1;

        // dut1: 10..20 step 2, across the 20->10 wrap
        v1 = 8'd10;
        for (int i = 0; i < 8; i++) begin
            send1(1'b1, v1);
            if (i == 2) check("w_prelock", {31'd0, bus1.locked}, 32'd0);
            if (i == 3) check("w_lock",    {31'd0, bus1.locked}, 32'd1);
            v1 = (v1 == 8'd20) ? 8'd10 : v1 + 8'd2;
        end
        check("w_no_err",   {31'd0, seen1}, 32'd0);
        check("w_wrap_lck", {31'd0, bus1.locked}, 32'd1);
        // 25 is above COUNT_TO: an ordinary mismatch
        send1(1'b1, 8'd25);
        check("w_oor_err", {31'd0, bus1.error}, 32'd1);
        check("w_oor_cnt", {16'd0, bus1.err_count}, 32'd1);
        send1(1'b0, 8'd25);
        check("w_pulse_end", {31'd0, bus1.error}, 32'd0);

        // dut0: clean stream, locks after sample 3, 300 samples
        cur = 8'd0;
        seen0 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            send0(1'b1, cur);
            if (i == 2) check("prelock", {31'd0, bus0.locked}, 32'd0);
            if (i == 3) check("lock",    {31'd0, bus0.locked}, 32'd1);
            cur = cur + 8'd1;
        end
        check("clean_no_err", {31'd0, seen0}, 32'd0);
        check("clean_cnt",    {16'd0, bus0.err_count}, 32'd0);

        // single replacement of 40 by 8'h55
        for (int i = 0; i < 256 && cur != 8'd40; i++) begin
            send0(1'b1, cur);
            cur = cur + 8'd1;
        end
        send0(1'b1, 8'h55);
        cur = cur + 8'd1;
        check("repl_err", {31'd0, bus0.error}, 32'd1);
        check("repl_cnt", {16'd0, bus0.err_count}, 32'd1);
        check("repl_lck", {31'd0, bus0.locked}, 32'd1);
        send0(1'b1, cur); cur = cur + 8'd1;
        check("repl_pulse", {31'd0, bus0.error}, 32'd0);
        send0(1'b1, cur); cur = cur + 8'd1;
        check("repl_hold", {31'd0, bus0.locked}, 32'd1);

        // clear with no sample
        bus0.clr_err = 1'b1;
        send0(1'b0, cur);
        bus0.clr_err = 1'b0;
        check("clr_cnt", {16'd0, bus0.err_count}, 32'd0);
        check("clr_err", {31'd0, bus0.error}, 32'd0);

        // three consecutive bad samples unlock
        for (int k = 0; k < 3; k++) begin
            send0(1'b1, cur ^ 8'h80);
            cur = cur + 8'd1;
            check("unl_cnt", {16'd0, bus0.err_count}, k + 1);
            check("unl_lck", {31'd0, bus0.locked}, (k < 2) ? 32'd1 : 32'd0);
        end
        check("unl_err", {31'd0, bus0.error}, 32'd1);

        // clean stream relocks after four samples
        for (int k = 0; k < 4; k++) begin
            send0(1'b1, cur);
            cur = cur + 8'd1;
            check("relock", {31'd0, bus0.locked}, (k == 3) ? 32'd1 : 32'd0);
        end
        check("relock_err", {31'd0, bus0.error}, 32'd0);

        // en toggling with input held while idle
        seen0 = 1'b0;
        for (int k = 0; k < 20; k++) begin
            send0(1'b1, cur);
            send0(1'b0, cur);
            cur = cur + 8'd1;
        end
        check("tog_no_err", {31'd0, seen0}, 32'd0);
        check("tog_lck",    {31'd0, bus0.locked}, 32'd1);
        check("tog_cnt",    {16'd0, bus0.err_count}, 32'd3);

        // bring err_count to 5 with non-consecutive misses
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        send0(1'b1, cur);         cur = cur + 8'd1;
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        check("five_cnt", {16'd0, bus0.err_count}, 32'd5);
        check("five_lck", {31'd0, bus0.locked}, 32'd1);

        // reset overrides a same-cycle bad sample
        rst = 1'b0;
        send0(1'b1, cur ^ 8'h80);
        rst = 1'b1;
        cur = cur + 8'd1;
        check("mid_rst_lck", {31'd0, bus0.locked}, 32'd0);
        check("mid_rst_cnt", {16'd0, bus0.err_count}, 32'd0);
        check("mid_rst_err", {31'd0, bus0.error}, 32'd0);

        // lock again from SEARCH
        for (int k = 0; k < 4; k++) begin
            send0(1'b1, cur);
            cur = cur + 8'd1;
            check("rst_relock", {31'd0, bus0.locked}, (k == 3) ? 32'd1 : 32'd0);
        end

        // a good sample between misses restarts the unlock run
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        send0(1'b1, cur);         cur = cur + 8'd1;
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        send0(1'b1, cur ^ 8'h80); cur = cur + 8'd1;
        check("miss_rst_lck", {31'd0, bus0.locked}, 32'd1);
        check("miss_rst_cnt", {16'd0, bus0.err_count}, 32'd4);

        // clear coincident with a bad sample
        send0(1'b1, cur); cur = cur + 8'd1;
        bus0.clr_err = 1'b1;
        send0(1'b1, cur ^ 8'h80);
        bus0.clr_err = 1'b0;
        cur = cur + 8'd1;
        check("clr_bad_err", {31'd0, bus0.error}, 32'd1);
        check("clr_bad_cnt", {16'd0, bus0.err_count}, 32'd0);
        send0(1'b0, cur);
        check("clr_bad_end", {31'd0, bus0.error}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_counter_checker
`default_nettype wire
